// File: rtl/attempt_guard.sv
// Attempt guard: turns code-checker results into timed unlocks, lockouts after
// repeated failures, and a latched alarm after repeated lockouts.
module attempt_guard #(
    parameter int unsigned CYCLES_PER_SEC = 50000000,
    parameter int unsigned OPEN_SECS      = 3,
    parameter int unsigned LOCKOUT_SECS   = 10,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned MAX_LOCKOUTS   = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       correct_pw,
    input  logic       invalid_pw,
    input  logic       relock,
    input  logic       alarm_clear,
    output logic       unlock,
    output logic       locked_out,
    output logic       alarm,
    output logic       submit_en,
    output logic [2:0] fail_cnt,
    output logic [3:0] secs_left
);

    localparam int unsigned PW = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CYCLES_PER_SEC - 1);
    localparam logic [2:0] FAIL_MAX  = 3'(MAX_FAILS);
    localparam logic [2:0] LOCK_MAX  = 3'(MAX_LOCKOUTS);
    localparam logic [3:0] OPEN_LOAD = 4'(OPEN_SECS);
    localparam logic [3:0] LOCK_LOAD = 4'(LOCKOUT_SECS);

    typedef enum logic [1:0] {
        StReady,
        StOpen,
        StLockout,
        StAlarm
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    secs_q, secs_d;
    logic [2:0]    fail_q, fail_d;
    logic [2:0]    lock_q, lock_d;
    logic          correct_q, invalid_q;
    logic          armed_q;

    logic          correct_ev, invalid_ev;
    logic          wrap;
    logic [2:0]    fail_inc, lock_inc;

    // armed_q masks the first sampled cycle so a level held through reset is no event
    assign correct_ev = armed_q & correct_pw & ~correct_q;
    assign invalid_ev = armed_q & invalid_pw & ~invalid_q;
    assign wrap       = (presc_q == PRESC_MAX);
    assign fail_inc   = (fail_q >= FAIL_MAX) ? FAIL_MAX : fail_q + 3'd1;
    assign lock_inc   = (lock_q >= LOCK_MAX) ? LOCK_MAX : lock_q + 3'd1;

    always_comb begin
        state_d = state_q;
        presc_d = wrap ? '0 : presc_q + PW'(1);
        secs_d  = secs_q;
        fail_d  = fail_q;
        lock_d  = lock_q;

        unique case (state_q)
            StReady: begin
                presc_d = '0;
                // A simultaneous correct result is deliberately overridden by a failure
                if (invalid_ev) begin
                    fail_d = fail_inc;
                    if (fail_inc == FAIL_MAX) begin
                        lock_d = lock_inc;
                        if (lock_inc == LOCK_MAX) begin
                            state_d = StAlarm;
                            secs_d  = 4'd0;
                        end else begin
                            state_d = StLockout;
                            secs_d  = LOCK_LOAD;
                        end
                    end
                end else if (correct_ev) begin
                    state_d = StOpen;
                    secs_d  = OPEN_LOAD;
                    fail_d  = 3'd0;
                    lock_d  = 3'd0;
                end
            end
            StOpen: begin
                if (relock) begin
                    state_d = StReady;
                    secs_d  = 4'd0;
                    presc_d = '0;
                end else if (wrap) begin
                    if (secs_q <= 4'd1) begin
                        state_d = StReady;
                        secs_d  = 4'd0;
                    end else begin
                        secs_d = secs_q - 4'd1;
                    end
                end
            end
            StLockout: begin
                if (wrap) begin
                    if (secs_q <= 4'd1) begin
                        state_d = StReady;
                        secs_d  = 4'd0;
                        fail_d  = 3'd0;
                    end else begin
                        secs_d = secs_q - 4'd1;
                    end
                end
            end
            StAlarm: begin
                presc_d = '0;
                secs_d  = 4'd0;
                if (alarm_clear) begin
                    state_d = StReady;
                    fail_d  = 3'd0;
                    lock_d  = 3'd0;
                end
            end
            default: begin
                state_d = StReady;
                presc_d = '0;
                secs_d  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StReady;
            presc_q    <= '0;
            secs_q     <= 4'd0;
            fail_q     <= 3'd0;
            lock_q     <= 3'd0;
            correct_q  <= 1'b0;
            invalid_q  <= 1'b0;
            armed_q    <= 1'b0;
            unlock     <= 1'b0;
            locked_out <= 1'b0;
            alarm      <= 1'b0;
            submit_en  <= 1'b1;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            secs_q     <= secs_d;
            fail_q     <= fail_d;
            lock_q     <= lock_d;
            correct_q  <= correct_pw;
            invalid_q  <= invalid_pw;
            armed_q    <= 1'b1;
            unlock     <= (state_d == StOpen);
            locked_out <= (state_d == StLockout) || (state_d == StAlarm);
            alarm      <= (state_d == StAlarm);
            submit_en  <= (state_d == StReady);
        end
    end

    assign fail_cnt  = fail_q;
    assign secs_left = secs_q;

endmodule
